// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline stage register with valid/ready handshake, optional
// 2-entry skid buffer, global stall, flush and a saturating backpressure counter.
module pipe_stage_buf #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall_pipeline,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_count
);

  localparam bit USE_SKID = (SKID != 0);

  // Encoding equals the number of held entries, so occupancy is the state flop.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire_c;
  logic             out_fire_c;

  // Handshake, next-state and datapath selection.
  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    cnt_d      = cnt_q;
    out_fire_c = out_valid_q & out_ready & ~stall_pipeline;

    if (USE_SKID) begin
      in_ready = (state_q != ST_FULL) & ~stall_pipeline;
    end else begin
      in_ready = ~stall_pipeline & (~out_valid_q | out_ready);
    end
    in_fire_c = in_valid & in_ready;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire_c) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire_c && out_fire_c) begin
          main_d = in_data;
        end else if (in_fire_c && USE_SKID) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (out_fire_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Older skid entry always drains into main before anything newer.
        if (out_fire_c) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush overrides stall and both transfers; payload regs may go stale.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    if (out_valid_q && !out_fire_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != ST_EMPTY);
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = main_q;
  assign occupancy   = 2'(state_q);
  assign stall_count = cnt_q;

endmodule
